// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and memory-stall freeze.
// Optional load-use stall counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        D_valid,
  input  logic [3:0]  D_Rs,
  input  logic [3:0]  D_Rt,
  input  logic [3:0]  D_Rd,
  input  logic        D_regWrite,
  input  logic        D_memRead,
  input  logic        D_memWrite,
  input  logic [1:0]  D_ALUsrc,
  input  logic [3:0]  D_ALUop,
  input  logic [15:0] D_rs_data,
  input  logic [15:0] D_rt_data,
  input  logic [15:0] D_imm,
  input  logic        flush,
  input  logic        mem_stall,
  output logic        X_valid,
  output logic [3:0]  X_Rs,
  output logic [3:0]  X_Rt,
  output logic [3:0]  X_Rd,
  output logic        X_regWrite,
  output logic        X_memRead,
  output logic        X_memWrite,
  output logic [1:0]  X_ALUsrc,
  output logic [3:0]  X_ALUop,
  output logic [15:0] X_rs_data,
  output logic [15:0] X_rt_data,
  output logic [15:0] X_imm,
  output logic        stall_D,
`ifdef ID_EX_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  output logic [1:0]  state
);

  typedef enum logic [1:0] {RUN = 2'b00, BUBBLE = 2'b01, HOLD = 2'b10} state_t;

  state_t      r_state, w_state_nxt;
  logic        w_load_use, w_load_d, w_load_bub;

  logic        r_valid, r_regWrite, r_memRead, r_memWrite;
  logic [3:0]  r_Rs, r_Rt, r_Rd, r_ALUop;
  logic [1:0]  r_ALUsrc;
  logic [15:0] r_rs_data, r_rt_data, r_imm;

  // A store's Rt is data for memory, forwarded later on the MEM-MEM path,
  // so it does not need a bubble; same for Rt when the ALU takes the immediate.
  always_comb begin
    w_load_use = X_valid & X_memRead & (X_Rd != 4'd0) & D_valid &
                 ((X_Rd == D_Rs) | ((X_Rd == D_Rt) & ~D_ALUsrc[1] & ~D_memWrite));
    w_state_nxt = RUN;
    stall_D     = 1'b0;
    w_load_bub  = 1'b0;
    w_load_d    = 1'b0;
    if (rst) begin
      w_state_nxt = RUN;
    end else if (mem_stall) begin
      w_state_nxt = HOLD;
      stall_D     = 1'b1;
    end else if (flush) begin
      w_load_bub  = 1'b1;
    end else if (w_load_use) begin
      w_state_nxt = BUBBLE;
      stall_D     = 1'b1;
      w_load_bub  = 1'b1;
    end else begin
      w_load_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || w_load_bub) begin
      r_valid    <= 1'b0;
      r_Rs       <= '0;
      r_Rt       <= '0;
      r_Rd       <= '0;
      r_regWrite <= 1'b0;
      r_memRead  <= 1'b0;
      r_memWrite <= 1'b0;
      r_ALUsrc   <= '0;
      r_ALUop    <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
    end else if (w_load_d) begin
      r_valid    <= D_valid;
      r_Rs       <= D_Rs;
      r_Rt       <= D_Rt;
      r_Rd       <= D_Rd;
      r_regWrite <= D_regWrite;
      r_memRead  <= D_memRead;
      r_memWrite <= D_memWrite;
      r_ALUsrc   <= D_ALUsrc;
      r_ALUop    <= D_ALUop;
      r_rs_data  <= D_rs_data;
      r_rt_data  <= D_rt_data;
      r_imm      <= D_imm;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  logic        w_cnt_inc;

  // Only a load-use bubble counts; a flush bubble leaves stall_D low.
  assign w_cnt_inc = w_load_bub & stall_D;

  always_ff @(posedge clk) begin
    if (rst)                                    r_stall_cnt <= '0;
    else if (w_cnt_inc && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign state      = r_state;
  assign X_valid    = r_valid;
  assign X_Rs       = r_Rs;
  assign X_Rt       = r_Rt;
  assign X_Rd       = r_Rd;
  assign X_regWrite = r_regWrite;
  assign X_memRead  = r_memRead;
  assign X_memWrite = r_memWrite;
  assign X_ALUsrc   = r_ALUsrc;
  assign X_ALUop    = r_ALUop;
  assign X_rs_data  = r_rs_data;
  assign X_rt_data  = r_rt_data;
  assign X_imm      = r_imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model pushes the expected X/state
// after each driven cycle; the entry is popped and compared once the edge has passed.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, flush, mem_stall;
  logic        D_valid, D_regWrite, D_memRead, D_memWrite;
  logic [3:0]  D_Rs, D_Rt, D_Rd, D_ALUop;
  logic [1:0]  D_ALUsrc;
  logic [15:0] D_rs_data, D_rt_data, D_imm;
  logic        X_valid, X_regWrite, X_memRead, X_memWrite, stall_D;
  logic [3:0]  X_Rs, X_Rt, X_Rd, X_ALUop;
  logic [1:0]  X_ALUsrc, state;
  logic [15:0] X_rs_data, X_rt_data, X_imm;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .D_valid(D_valid), .D_Rs(D_Rs), .D_Rt(D_Rt), .D_Rd(D_Rd),
    .D_regWrite(D_regWrite), .D_memRead(D_memRead), .D_memWrite(D_memWrite),
    .D_ALUsrc(D_ALUsrc), .D_ALUop(D_ALUop),
    .D_rs_data(D_rs_data), .D_rt_data(D_rt_data), .D_imm(D_imm),
    .flush(flush), .mem_stall(mem_stall),
    .X_valid(X_valid), .X_Rs(X_Rs), .X_Rt(X_Rt), .X_Rd(X_Rd),
    .X_regWrite(X_regWrite), .X_memRead(X_memRead), .X_memWrite(X_memWrite),
    .X_ALUsrc(X_ALUsrc), .X_ALUop(X_ALUop),
    .X_rs_data(X_rs_data), .X_rt_data(X_rt_data), .X_imm(X_imm),
    .stall_D(stall_D),
`ifdef ID_EX_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .state(state)
  );

`ifndef ID_EX_STALL_CNT_EN
  assign stall_cnt = 16'd0;
`endif

  typedef struct packed {
    logic [69:0] x;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0, n_pass = 0;
  logic [69:0] m_x = '0;
  logic [1:0]  m_st = 2'b00;
  logic [15:0] m_cnt = '0;

  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic set_d(input logic v, input logic [3:0] rs, rt, rd, input logic rw, mr, mw,
                       input logic [1:0] src, input logic [3:0] op, input logic [15:0] a, b, imm);
    D_valid = v; D_Rs = rs; D_Rt = rt; D_Rd = rd;
    D_regWrite = rw; D_memRead = mr; D_memWrite = mw;
    D_ALUsrc = src; D_ALUop = op; D_rs_data = a; D_rt_data = b; D_imm = imm;
  endtask

  // One clock: drive at negedge, check stall_D, advance model, compare X after posedge.
  task automatic step(input logic f, input logic ms, input logic r);
    logic        lu, exp_stall;
    logic [3:0]  xrd;
    logic [69:0] dvec;
    exp_t        e;
    @(negedge clk);
    flush = f; mem_stall = ms; rst = r;
    #1;
    xrd = m_x[60:57];
    lu  = m_x[69] && m_x[55] && (xrd != 4'd0) && D_valid &&
          ((xrd == D_Rs) || (xrd == D_Rt && !D_ALUsrc[1] && !D_memWrite));
    exp_stall = !r && (ms || (!f && lu));
    chk("stall_D", {69'd0, stall_D}, {69'd0, exp_stall});
    dvec = {D_valid, D_Rs, D_Rt, D_Rd, D_regWrite, D_memRead, D_memWrite,
            D_ALUsrc, D_ALUop, D_rs_data, D_rt_data, D_imm};
    if (r)       begin m_x = '0; m_st = 2'b00; m_cnt = '0; end
    else if (ms) begin m_st = 2'b10; end
    else if (f)  begin m_x = '0; m_st = 2'b00; end
    else if (lu) begin
      m_x = '0; m_st = 2'b01;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    else         begin m_x = dvec; m_st = 2'b00; end
    sb_q.push_back('{x: m_x, st: m_st, cnt: m_cnt});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("X_fields", {X_valid, X_Rs, X_Rt, X_Rd, X_regWrite, X_memRead, X_memWrite,
                     X_ALUsrc, X_ALUop, X_rs_data, X_rt_data, X_imm}, e.x);
    chk("state", {68'd0, state}, {68'd0, e.st});
`ifdef ID_EX_STALL_CNT_EN
    chk("stall_cnt", {54'd0, stall_cnt}, {54'd0, e.cnt});
`endif
  endtask

  // Canned instructions (ALUsrc: 00 reg, 01 imm for address, 10 imm for Rt slot)
  task automatic d_lw(input logic [3:0] rs, rd);
    set_d(1, rs, 4'd0, rd, 1, 1, 0, 2'b10, 4'h1, 16'h1000, 16'h0, 16'h0004);
  endtask
  task automatic d_add(input logic [3:0] rs, rt, rd);
    set_d(1, rs, rt, rd, 1, 0, 0, 2'b00, 4'h2, 16'h00AA, 16'h0055, 16'h0);
  endtask

  initial begin
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    flush = 0; mem_stall = 0; rst = 1;
    step(0, 0, 1);
    step(0, 0, 1);

    // load-use on Rs: one bubble, then the ADD loads
    d_lw(4'd1, 4'd3);     step(0, 0, 0);
    d_add(4'd3, 4'd4, 4'd5); step(0, 0, 0);
    step(0, 0, 0);

    // store data hazard on Rt: no stall
    d_lw(4'd1, 4'd3);     step(0, 0, 0);
    set_d(1, 4'd5, 4'd3, 4'd0, 0, 0, 1, 2'b10, 4'h1, 16'h2000, 16'h1234, 16'h0008);
    step(0, 0, 0);

    // load into r0 never hazards
    d_lw(4'd1, 4'd0);     step(0, 0, 0);
    d_add(4'd0, 4'd0, 4'd6); step(0, 0, 0);

    // mem_stall holds ADD r7 for 3 cycles, then next instr loads
    d_add(4'd1, 4'd2, 4'd7); step(0, 0, 0);
    d_add(4'd7, 4'd8, 4'd9);
    repeat (3) step(0, 1, 0);
    step(0, 0, 0);

    // flush and load_use together: bubble, no stall
    d_lw(4'd1, 4'd3);     step(0, 0, 0);
    d_add(4'd3, 4'd4, 4'd5); step(1, 0, 0);

    // five load-use events then reset
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      d_lw(4'd1, 4'd2);        step(0, 0, 0);
      d_add(4'd2, 4'd2, 4'd4); step(0, 0, 0);
      step(0, 0, 0);
    end
    step(0, 0, 1);

    // random traffic over a small register file to make hazards common
    for (int i = 0; i < 400; i++) begin
      set_d($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
            2'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      step($urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 40) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
